// File: rtl/seg_scan_bcd.sv
// Multiplexed 7-segment driver with a sequential binary-to-BCD converter.
// A load strobe captures a binary value, saturating it to the largest
// displayable value. The value is converted by shift-add-3, one bit per
// clock, and the result is committed atomically to the display register.
// The display register is scanned across DIGITS active-low anodes.
module seg_scan_bcd #(
  parameter int DIGITS      = 4,
  parameter int BIN_W       = 15,
  parameter int REFRESH_DIV = 1,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic              segclk,
  input  logic              clr,
  input  logic [BIN_W-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic              ovf,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Largest displayable value, and whether a BIN_W-bit input can exceed it.
  localparam longint unsigned MAX_L   = pow10(DIGITS) - 1;
  localparam bit              CAN_OVF = ((MAX_L >> BIN_W) == 0);
  localparam logic [BIN_W-1:0] MAX_B  = BIN_W'(MAX_L);

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   bcd_q, bcd_adj, disp_q;
  logic               pend_ovf;

  logic [PRE_W-1:0]   presc;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         nib;
  logic [DIGITS-1:0]  lz;
  logic               blank;
  logic [6:0]         seg_nxt;
  logic [DIGITS-1:0]  an_nxt;

  // Conversion FSM state register.
  always_ff @(posedge segclk or posedge clr) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block evaluation order.
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> CONVERT for BIN_W steps -> COMMIT -> IDLE.
  always_comb begin
    // NOTE: defaulting first guarantees every path assigns, so no latch.
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = CONVERT;
      CONVERT: if (bit_cnt == CNT_W'(BIN_W - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath: capture with saturation, shift, then commit.
  always_ff @(posedge segclk or posedge clr) begin
    if (clr) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      bit_cnt  <= '0;
      pend_ovf <= 1'b0;
      // NOTE: the display register is reset explicitly so the panel shows a
      // defined zero after reset and an aborted conversion never leaks out.
      disp_q   <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bcd_q   <= '0;
            bit_cnt <= '0;
            if (CAN_OVF && (value > MAX_B)) begin
              bin_q    <= MAX_B;
              pend_ovf <= 1'b1;
            end else begin
              bin_q    <= value;
              pend_ovf <= 1'b0;
            end
          end
        end
        CONVERT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          bit_cnt        <= bit_cnt + CNT_W'(1);
        end
        COMMIT: begin
          disp_q <= bcd_q;
          ovf    <= pend_ovf;
        end
        default: ;
      endcase
    end
  end

  // Scan timing: prescaler sets the dwell, index walks the digits.
  always_ff @(posedge segclk or posedge clr) begin
    if (clr) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRE_W'(REFRESH_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  // Digit select, leading-zero detection and segment decode for the index.
  always_comb begin
    logic run;
    nib    = 4'd0;
    blank  = 1'b0;
    an_nxt = '1;
    lz     = '0;
    run    = 1'b1;
    // lz[i] is set when nibbles i..DIGITS-1 are all zero.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run   = run && (disp_q[4*i +: 4] == 4'd0);
      lz[i] = run;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib       = disp_q[4*i +: 4];
        an_nxt[i] = 1'b0;
        blank     = BLANK_LZ && (i != 0) && lz[i];
      end
    end
    case (nib)
      4'd0:    seg_nxt = 7'b1000000;
      4'd1:    seg_nxt = 7'b1111001;
      4'd2:    seg_nxt = 7'b0100100;
      4'd3:    seg_nxt = 7'b0110000;
      4'd4:    seg_nxt = 7'b0011001;
      4'd5:    seg_nxt = 7'b0010010;
      4'd6:    seg_nxt = 7'b0000010;
      4'd7:    seg_nxt = 7'b1111000;
      4'd8:    seg_nxt = 7'b0000000;
      4'd9:    seg_nxt = 7'b0010000;
      default: seg_nxt = 7'b1111111;
    endcase
    if (blank) seg_nxt = 7'b1111111;
  end

  // Registered pin drivers; blank and all anodes off during reset.
  always_ff @(posedge segclk or posedge clr) begin
    if (clr) begin
      seg <= 7'b1111111;
      an  <= '1;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_bcd.sv
// Directed bench for seg_scan_bcd: a table of load values with expected
// per-digit segment codes, plus hand sequences for reset scanning, ignored
// loads, mid-conversion clear and a 6-digit / 3-cycle-dwell variant.
module tb_seg_scan_bcd;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SB = 7'b1111111;

  logic segclk = 1'b0;
  logic clr    = 1'b0;
  always #5 segclk = ~segclk;

  // A: defaults (4 digits, 15 bits, dwell 1, blanking on)
  logic [14:0] a_value;
  logic        a_load, a_busy, a_ovf;
  logic [6:0]  a_seg;
  logic [3:0]  a_an;
  // B: blanking off
  logic [14:0] b_value;
  logic        b_load, b_busy, b_ovf;
  logic [6:0]  b_seg;
  logic [3:0]  b_an;
  // C: 6 digits, 20 bits, dwell 3
  logic [19:0] c_value;
  logic        c_load, c_busy, c_ovf;
  logic [6:0]  c_seg;
  logic [5:0]  c_an;

  seg_scan_bcd dut_a (.segclk(segclk), .clr(clr), .value(a_value), .load(a_load),
                      .busy(a_busy), .ovf(a_ovf), .seg(a_seg), .an(a_an));
  seg_scan_bcd #(.BLANK_LZ(1'b0)) dut_b (.segclk(segclk), .clr(clr), .value(b_value),
                      .load(b_load), .busy(b_busy), .ovf(b_ovf), .seg(b_seg), .an(b_an));
  seg_scan_bcd #(.DIGITS(6), .BIN_W(20), .REFRESH_DIV(3)) dut_c (.segclk(segclk),
                      .clr(clr), .value(c_value), .load(c_load), .busy(c_busy),
                      .ovf(c_ovf), .seg(c_seg), .an(c_an));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string            name;
    logic [14:0]      value;
    logic [3:0][6:0]  segs;   // [3]=digit3 ... [0]=digit0
    logic             ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return a_busy;
      1:       return b_busy;
      default: return c_busy;
    endcase
  endfunction

  // Pulse load for one edge; returns at the negedge after the capture edge.
  task automatic start_load(input int sel, input logic [19:0] v);
    @(negedge segclk);
    case (sel)
      0:       begin a_value = v[14:0]; a_load = 1'b1; end
      1:       begin b_value = v[14:0]; b_load = 1'b1; end
      default: begin c_value = v;       c_load = 1'b1; end
    endcase
    @(negedge segclk);
    a_load = 1'b0;
    b_load = 1'b0;
    c_load = 1'b0;
  endtask

  // Counts negedge samples with busy high (bounded).
  task automatic count_busy(input int sel, output int cyc);
    cyc = 0;
    while (busy_of(sel) && cyc < 100) begin
      cyc++;
      @(negedge segclk);
    end
  endtask

  // Finds the lit digit of a 4-digit display and compares its segments.
  task automatic check_digit(input string name, input logic [3:0] an_v,
                             input logic [6:0] seg_v, input logic [3:0][6:0] exp);
    int d = -1;
    logic [3:0] m;
    for (int i = 0; i < 4; i++) begin
      m = ~(4'b0001 << i);
      if (an_v == m) d = i;
    end
    if (d < 0) check({name, " an one-hot"}, {28'd0, an_v}, 32'h0000000E);
    else       check($sformatf("%s d%0d", name, d), {25'd0, seg_v}, {25'd0, exp[d]});
  endtask

  // Skip one cycle so seg reflects the committed value, then scan all digits.
  task automatic check_scan4(input int sel, input logic [3:0][6:0] exp, input string name);
    @(negedge segclk);
    for (int k = 0; k < 4; k++) begin
      if (sel == 0) check_digit(name, a_an, a_seg, exp);
      else          check_digit(name, b_an, b_seg, exp);
      @(negedge segclk);
    end
  endtask

  initial begin
    int cyc;
    logic [3:0] ea;
    logic [5:0] ec;
    logic [6:0] es;
    string nm;

    a_value = '0; a_load = 1'b0;
    b_value = '0; b_load = 1'b0;
    c_value = '0; c_load = 1'b0;

    vecs.push_back('{"v1234",  15'd1234,  {S1, S2, S3, S4}, 1'b0});
    vecs.push_back('{"v20000", 15'd20000, {S9, S9, S9, S9}, 1'b1});
    vecs.push_back('{"v5",     15'd5,     {SB, SB, SB, S5}, 1'b0});
    vecs.push_back('{"v7",     15'd7,     {SB, SB, SB, S7}, 1'b0});
    vecs.push_back('{"v0",     15'd0,     {SB, SB, SB, S0}, 1'b0});
    vecs.push_back('{"v9999",  15'd9999,  {S9, S9, S9, S9}, 1'b0});
    vecs.push_back('{"v10000", 15'd10000, {S9, S9, S9, S9}, 1'b1});
    vecs.push_back('{"v1005",  15'd1005,  {S1, S0, S0, S5}, 1'b0});
    vecs.push_back('{"v60",    15'd60,    {SB, SB, S6, S0}, 1'b0});
    vecs.push_back('{"v32767", 15'd32767, {S9, S9, S9, S9}, 1'b1});
    vecs.push_back('{"v830",   15'd830,   {SB, S8, S3, S0}, 1'b0});

    // Reset values while clr is held.
    #1 clr = 1'b1;
    repeat (3) @(negedge segclk);
    check("rst a_an",   {28'd0, a_an},  32'hF);
    check("rst a_seg",  {25'd0, a_seg}, {25'd0, SB});
    check("rst a_busy", {31'd0, a_busy}, 32'd0);
    check("rst a_ovf",  {31'd0, a_ovf},  32'd0);
    check("rst c_an",   {26'd0, c_an},  32'h3F);

    // Release; scanning starts on the next edge.
    clr = 1'b0;
    @(negedge segclk);
    for (int k = 0; k < 18; k++) begin
      ea = ~(4'b0001 << (k % 4));
      es = (k % 4 == 0) ? S0 : SB;
      check($sformatf("scan a_an k%0d", k),  {28'd0, a_an},  {28'd0, ea});
      check($sformatf("scan a_seg k%0d", k), {25'd0, a_seg}, {25'd0, es});
      check($sformatf("scan b_seg k%0d", k), {25'd0, b_seg}, {25'd0, S0});
      ec = ~(6'b000001 << (k / 3));
      es = (k / 3 == 0) ? S0 : SB;
      check($sformatf("scan c_an k%0d", k),  {26'd0, c_an},  {26'd0, ec});
      check($sformatf("scan c_seg k%0d", k), {25'd0, c_seg}, {25'd0, es});
      @(negedge segclk);
    end

    // Wide variant: 999999 needs 21 busy cycles and shows all nines.
    start_load(2, 20'd999999);
    count_busy(2, cyc);
    check("c busy len", cyc, 21);
    check("c ovf", {31'd0, c_ovf}, 32'd0);
    @(negedge segclk);
    for (int k = 0; k < 18; k++) begin
      check($sformatf("c nines k%0d", k), {25'd0, c_seg}, {25'd0, S9});
      check($sformatf("c an onehot k%0d", k), $countones(~c_an), 32'd1);
      @(negedge segclk);
    end

    // Blanking disabled: 7 shows with explicit leading zeros.
    start_load(1, 20'd7);
    count_busy(1, cyc);
    check("b busy len", cyc, 16);
    check_scan4(1, {S0, S0, S0, S7}, "b v7");

    // Table of load vectors on the default instance.
    foreach (vecs[i]) begin
      start_load(0, {5'd0, vecs[i].value});
      count_busy(0, cyc);
      check({vecs[i].name, " busy len"}, cyc, 16);
      check({vecs[i].name, " ovf"}, {31'd0, a_ovf}, {31'd0, vecs[i].ovf});
      check_scan4(0, vecs[i].segs, vecs[i].name);
    end

    // Old value (830) stays visible during conversion; load of 42 while busy is ignored.
    start_load(0, 20'd1234);
    cyc = 0;
    while (a_busy && cyc < 100) begin
      cyc++;
      if (cyc >= 2 && cyc <= 4) check_digit("hold 830", a_an, a_seg, {SB, S8, S3, S0});
      if (cyc == 5) begin a_value = 15'd42; a_load = 1'b1; end
      else a_load = 1'b0;
      @(negedge segclk);
    end
    a_load = 1'b0;
    check("ignore busy len", cyc, 16);
    check_scan4(0, {S1, S2, S3, S4}, "ignore 42");

    // Set ovf, then abort a conversion with clr at busy cycle 8.
    start_load(0, 20'd20000);
    count_busy(0, cyc);
    check("pre-abort ovf", {31'd0, a_ovf}, 32'd1);
    start_load(0, 20'd5678);
    repeat (7) @(negedge segclk);
    check("abort busy pre", {31'd0, a_busy}, 32'd1);
    clr = 1'b1;
    #1;
    check("abort an",   {28'd0, a_an},   32'hF);
    check("abort seg",  {25'd0, a_seg},  {25'd0, SB});
    check("abort busy", {31'd0, a_busy}, 32'd0);
    check("abort ovf",  {31'd0, a_ovf},  32'd0);
    @(negedge segclk);
    clr = 1'b0;
    check_scan4(0, {SB, SB, SB, S0}, "after abort");
    repeat (25) @(negedge segclk);
    check("late busy", {31'd0, a_busy}, 32'd0);
    check_scan4(0, {SB, SB, SB, S0}, "no late commit");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
